// File: rtl/seq_mult_8bit_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier.
package seq_mult_8bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ITER = 8;

endpackage

// File: rtl/mux2_1_8bit.sv
// 8-bit 2:1 mux; s=1 selects in1, s=0 selects in2.
module mux2_1_8bit (
    input  logic       s,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    output logic [7:0] y
);

    assign y = s ? in1 : in2;

endmodule

// File: rtl/seq_mult_8bit.sv
// Unsigned 8x8 shift-and-add multiplier with start/done handshake.
module seq_mult_8bit
    import seq_mult_8bit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  m;
    logic [7:0]  p_hi;
    logic [7:0]  q;
    logic [7:0]  addend;
    logic [2:0]  count;
    logic [8:0]  sum;
    logic [15:0] shifted;
    logic        accept;
    logic        last;

    mux2_1_8bit u_mux (
        .s   (q[0]),
        .in1 (m),
        .in2 (8'h00),
        .y   (addend)
    );

    // sum[8] is the carry that becomes the top bit of the shifted pair
    assign sum     = {1'b0, p_hi} + {1'b0, addend};
    assign shifted = {sum, q[7:1]};
    assign accept  = start && (state == IDLE || state == DONE);
    assign last    = (count == 3'(ITER - 1));

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= 8'h00;
            p_hi    <= 8'h00;
            q       <= 8'h00;
            count   <= 3'd0;
            product <= 16'h0000;
        end else if (accept) begin
            m     <= a;
            q     <= b;
            p_hi  <= 8'h00;
            count <= 3'd0;
        end else if (state == CALC) begin
            {p_hi, q} <= shifted;
            count     <= count + 3'd1;
            if (last) begin
                product <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Self-checking bench for seq_mult_8bit: directed cases plus random pairs.
module tb_seq_mult_8bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;

    seq_mult_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge after the accept edge; lat = busy cycles still due.
    task automatic wait_result(input string tag, input int lat,
                               input logic [15:0] exp);
        int cyc;
        cyc = 0;
        while (!done && cyc < 20) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            cyc++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_excl"}, 32'(busy & done), 32'd0);
        check({tag, "_product"}, 32'(product), 32'(exp));
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input string tag);
        logic [15:0] exp;
        exp = 16'(x) * 16'(y);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        wait_result(tag, 8, exp);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst = 1'b0;

        run_op(8'd13, 8'd11, "mul13x11");
        run_op(8'd255, 8'd255, "mul255x255");
        run_op(8'd0, 8'd200, "mul0x200");
        run_op(8'd200, 8'd0, "mul200x0");

        // Request during CALC is ignored, then taken back-to-back from DONE
        @(negedge clk);
        start = 1'b1;
        a     = 8'd7;
        b     = 8'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        wait_result("b2b_first", 6, 16'd42);
        @(negedge clk);
        check("b2b_reaccept_busy", 32'(busy), 32'd1);
        check("b2b_reaccept_done", 32'(done), 32'd0);
        check("b2b_hold42", 32'(product), 32'd42);
        start = 1'b0;
        wait_result("b2b_second", 8, 16'd81);
        @(negedge clk);
        check("b2b_pulse", 32'(done), 32'd0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_product", 32'(product), 32'd0);
        run_op(8'd5, 8'd5, "mul5x5");

        for (int i = 0; i < 200; i++) begin
            run_op(8'($urandom), 8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
